var_delay_ctrl: RTL and testbench

VAR_DELAY_CTRL -- requirements
Module: var_delay_ctrl

---
 rtl/var_delay_pkg.sv | 19 +
 rtl/var_delay_ram.sv | 47 ++++
 rtl/var_delay_ctrl.sv | 124 ++++++++++++
 tb/tb_var_delay_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/var_delay_pkg.sv
// Shared definitions for the variable delay line: FSM states, config width
// and the address-width helper.
package var_delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CFG_DLY_W = 9;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/var_delay_ram.sv
// Delay-line storage: one write port, one registered read port (read-first),
// with a resettable valid bit per entry.
module var_delay_ram
    import var_delay_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  mem_vld;

    always_ff @(posedge clk) begin
        if (en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_vld <= '0;
        end else if (en) begin
            mem_vld[wr_addr] <= wr_vld;
        end
    end

    // Read stage: returns the entry as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else if (en) begin
            rd_vld  <= mem_vld[rd_addr];
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/var_delay_ctrl.sv
// Variable delay line controller with runtime-reconfigurable delay.
// Define VAR_DELAY_FLUSH_EN to force out to zero while refilling.
module var_delay_ctrl
    import var_delay_pkg::*;
#(
    parameter int WIDTH_SIGNAL  = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WIDTH_SIGNAL-1:0] in,
    input  logic                    in_vld,
    input  logic                    cfg_req,
    input  logic [CFG_DLY_W-1:0]    cfg_dly,
    output logic                    cfg_ack,
    output logic                    cfg_err,
    output logic [WIDTH_SIGNAL-1:0] out,
    output logic                    out_vld,
    output logic                    busy
);

    localparam int                   ADDR_W  = clog2(MAX_DELAY);
    localparam logic [CFG_DLY_W-1:0] MAX_D   = CFG_DLY_W'(MAX_DELAY);
    localparam logic [ADDR_W-1:0]    WP_LAST = ADDR_W'(MAX_DELAY - 1);

    function automatic logic [CFG_DLY_W-1:0] sat_dly(input logic [CFG_DLY_W-1:0] req);
        if (req == '0) return CFG_DLY_W'(1);
        if (req > MAX_D) return MAX_D;
        return req;
    endfunction

    function automatic logic dly_clamped(input logic [CFG_DLY_W-1:0] req);
        return (req == '0) || (req > MAX_D);
    endfunction

    // Modular subtract done in the wider config width so d == MAX_DELAY works.
    function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] ptr,
                                                   input logic [CFG_DLY_W-1:0] d);
        logic [CFG_DLY_W-1:0] p;
        p = CFG_DLY_W'(ptr);
        if (p >= d) return ADDR_W'(p - d);
        return ADDR_W'(p + MAX_D - d);
    endfunction

    state_t                  state, state_nxt;
    logic [CFG_DLY_W-1:0]    dly, fill_cnt;
    logic [ADDR_W-1:0]       wp, rd_addr;
    logic                    accept;
    logic                    vld_gate_p1, rd_vld_p1;
    logic [WIDTH_SIGNAL-1:0] rd_data_p1;

    assign accept  = en & cfg_req;
    // The read register lands one edge later, so reading wp - D now yields
    // the sample written D en-cycles before the edge that presents it.
    assign rd_addr = wrap_sub(wp, dly);

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            if (accept) begin
                state_nxt = FILL;
            end else if (state == FILL && fill_cnt == dly - CFG_DLY_W'(1)) begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly         <= CFG_DLY_W'(DEFAULT_DELAY);
            fill_cnt    <= '0;
            wp          <= '0;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
            vld_gate_p1 <= 1'b0;
        end else begin
            cfg_ack <= accept;
            if (en) begin
                wp          <= (wp == WP_LAST) ? '0 : wp + ADDR_W'(1);
                vld_gate_p1 <= (state == RUN) && !accept;
                if (accept) begin
                    dly      <= sat_dly(cfg_dly);
                    fill_cnt <= '0;
                    if (dly_clamped(cfg_dly)) cfg_err <= 1'b1;
                end else if (state == FILL) begin
                    fill_cnt <= fill_cnt + CFG_DLY_W'(1);
                end
            end
        end
    end

    var_delay_ram #(
        .DATA_W (WIDTH_SIGNAL),
        .DEPTH  (MAX_DELAY),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_addr (wp),
        .wr_vld  (in_vld),
        .wr_data (in),
        .rd_addr (rd_addr),
        .rd_vld  (rd_vld_p1),
        .rd_data (rd_data_p1)
    );

    // Output stage: read register gated by the fill state.
`ifdef VAR_DELAY_FLUSH_EN
    assign out = (state == FILL) ? '0 : rd_data_p1;
`else
    assign out = rd_data_p1;
`endif
    assign out_vld = vld_gate_p1 & rd_vld_p1;
    assign busy    = (state == FILL);

endmodule

// File: tb/tb_var_delay_ctrl.sv
// Self-checking bench for var_delay_ctrl against a sample-history model.
module tb_var_delay_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, in_vld, cfg_req;
    logic [7:0] d_in;
    logic [8:0] cfg_dly;
    logic       cfg_ack, cfg_err, out_vld, busy;
    logic [7:0] d_out;

    int checks = 0;
    int fails  = 0;

    // Model: history of samples taken on en cycles, active delay, and
    // number of en cycles since the last restart (reset or accepted config).
    logic [8:0] hist[$];
    int         m_d, m_cnt;
    bit         m_err, m_ack;

    var_delay_ctrl #(
        .WIDTH_SIGNAL  (8),
        .MAX_DELAY     (16),
        .DEFAULT_DELAY (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in      (d_in),
        .in_vld  (in_vld),
        .cfg_req (cfg_req),
        .cfg_dly (cfg_dly),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .out     (d_out),
        .out_vld (out_vld),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic bit m_busy();
        return m_cnt < m_d;
    endfunction

    function automatic bit m_ok();
        return m_cnt > m_d;
    endfunction

    function automatic logic [8:0] m_sample();
        return hist[hist.size() - 1 - m_d];
    endfunction

    task automatic tick(input logic e, input logic [7:0] d, input logic v,
                        input logic rq, input logic [8:0] dl, input logic r);
        en = e; d_in = d; in_vld = v; cfg_req = rq; cfg_dly = dl; rst = r;
        @(posedge clk);
        if (r) begin
            m_d = 3; m_cnt = 0; m_err = 0; m_ack = 0;
            hist.delete();
        end else begin
            m_ack = e && rq;
            if (e) begin
                hist.push_back({v, d});
                if (hist.size() > 64) void'(hist.pop_front());
                if (rq) begin
                    m_d   = (dl == 0) ? 1 : (dl > 16) ? 16 : int'(dl);
                    m_err = m_err || (dl == 0) || (dl > 16);
                    m_cnt = 0;
                end else if (m_cnt < 1000) begin
                    m_cnt++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 8'hAA, 1, 1, 9'd5, 1);
        tick(1, 8'h55, 1, 1, 9'd0, 1);
        checks++; if (d_out !== 8'd0) begin fails++; $display("FAIL reset_out: got %h want 00", d_out); end
        checks++; if (out_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", out_vld); end
        checks++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", cfg_ack); end
        checks++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 16; i++) begin
            tick(1, 8'(i + 1), 1, 0, 9'd0, 0);
            checks++; if (out_vld !== (i >= 3)) begin fails++; $display("FAIL lat_vld cycle %0d: got %b want %b", i, out_vld, i >= 3); end
            checks++; if (busy !== (i < 2)) begin fails++; $display("FAIL lat_busy cycle %0d: got %b want %b", i, busy, i < 2); end
            if (i >= 3) begin
                checks++; if (d_out !== 8'(i - 2)) begin fails++; $display("FAIL lat_out cycle %0d: got %0d want %0d", i, d_out, i - 2); end
            end
        end
    endtask

    task automatic test_reconfig();
        int low;
        logic [8:0] s;
        tick(1, 8'($urandom), 1, 1, 9'd7, 0);
        checks++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL cfg7_ack: got %b want 1", cfg_ack); end
        checks++; if (out_vld !== 1'b0) begin fails++; $display("FAIL cfg7_ackvld: got %b want 0", out_vld); end
        low = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1, 8'($urandom), 1, 0, 9'd0, 0);
            if (i == 0) begin
                checks++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL cfg7_pulse: got %b want 0", cfg_ack); end
            end
            if (out_vld === 1'b0 && i < 12) low++;
            s = m_ok() ? m_sample() : 9'd0;
            checks++; if (busy !== m_busy()) begin fails++; $display("FAIL cfg7_busy cycle %0d: got %b want %b", i, busy, m_busy()); end
            if (m_ok()) begin
                checks++; if (d_out !== s[7:0]) begin fails++; $display("FAIL cfg7_out cycle %0d: got %h want %h", i, d_out, s[7:0]); end
            end
        end
        checks++; if (low != 7) begin fails++; $display("FAIL cfg7_gap: got %0d want 7", low); end
    endtask

    task automatic test_clamp();
        logic [8:0] s;
        tick(1, 8'($urandom), 1, 1, 9'd0, 0);
        tick(1, 8'h11, 1, 0, 9'd0, 0);
        checks++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL clamp0_err: got %b want 1", cfg_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL clamp0_busy: got %b want 0", busy); end
        tick(1, 8'h22, 1, 0, 9'd0, 0);
        checks++; if (d_out !== 8'h11 || out_vld !== 1'b1) begin fails++; $display("FAIL clamp0_out: got %h/%b want 11/1", d_out, out_vld); end
        tick(1, 8'($urandom), 1, 1, 9'd20, 0);
        for (int i = 0; i < 45; i++) begin
            tick(1, 8'($urandom), 1'($urandom), 0, 9'd0, 0);
            s = m_ok() ? m_sample() : 9'd0;
            checks++; if (out_vld !== (m_ok() && s[8])) begin fails++; $display("FAIL clamp16_vld cycle %0d: got %b want %b", i, out_vld, m_ok() && s[8]); end
            if (m_ok()) begin
                checks++; if (d_out !== s[7:0]) begin fails++; $display("FAIL clamp16_out cycle %0d: got %h want %h", i, d_out, s[7:0]); end
            end
        end
        checks++; if (busy !== (m_d != 16)) begin fails++; $display("FAIL clamp16_busy: got %b want 0", busy); end
        checks++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL clamp_sticky: got %b want 1", cfg_err); end
    endtask

    task automatic test_en_toggle();
        logic [8:0] s;
        tick(1, 8'($urandom), 1, 1, 9'd4, 0);
        for (int i = 0; i < 40; i++) begin
            tick(i % 2 == 1, 8'($urandom), 1'($urandom), i % 2 == 0, 9'd9, 0);
            if (i % 2 == 0) begin
                checks++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL en_noack cycle %0d: got %b want 0", i, cfg_ack); end
            end
            s = m_ok() ? m_sample() : 9'd0;
            checks++; if (out_vld !== (m_ok() && s[8])) begin fails++; $display("FAIL en_vld cycle %0d: got %b want %b", i, out_vld, m_ok() && s[8]); end
            if (m_ok()) begin
                checks++; if (d_out !== s[7:0]) begin fails++; $display("FAIL en_out cycle %0d: got %h want %h", i, d_out, s[7:0]); end
            end
        end
    endtask

    task automatic test_fill_restart();
        logic [8:0] s;
        tick(1, 8'($urandom), 1, 1, 9'd10, 0);
        for (int i = 0; i < 5; i++) tick(1, 8'($urandom), 1, 0, 9'd0, 0);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy10: got %b want 1", busy); end
        tick(1, 8'($urandom), 1, 1, 9'd2, 0);
        checks++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL restart_ack: got %b want 1", cfg_ack); end
        for (int i = 0; i < 12; i++) begin
            tick(1, 8'($urandom), 1, 0, 9'd0, 0);
            if (i == 1) begin
                checks++; if (busy !== 1'b0) begin fails++; $display("FAIL restart_run: got %b want 0", busy); end
            end
            s = m_ok() ? m_sample() : 9'd0;
            checks++; if (out_vld !== (m_ok() && s[8])) begin fails++; $display("FAIL restart_vld cycle %0d: got %b want %b", i, out_vld, m_ok() && s[8]); end
            if (m_ok()) begin
                checks++; if (d_out !== s[7:0]) begin fails++; $display("FAIL restart_out cycle %0d: got %h want %h", i, d_out, s[7:0]); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] s;
        for (int i = 0; i < 5; i++) tick(1, 8'($urandom), 1, 0, 9'd0, 0);
        tick(1, 8'hC3, 1, 1, 9'd9, 1);
        checks++; if (d_out !== 8'd0 || out_vld !== 1'b0) begin fails++; $display("FAIL midrst_out: got %h/%b want 00/0", d_out, out_vld); end
        checks++; if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin fails++; $display("FAIL midrst_cfg: got %b/%b want 0/0", cfg_ack, cfg_err); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy: got %b want 1", busy); end
        for (int i = 0; i < 10; i++) begin
            tick(1, 8'(8'h40 + i), 1, 0, 9'd0, 0);
            checks++; if (busy !== (i < 2)) begin fails++; $display("FAIL midrst_fill cycle %0d: got %b want %b", i, busy, i < 2); end
            checks++; if (out_vld !== (i >= 3)) begin fails++; $display("FAIL midrst_vld cycle %0d: got %b want %b", i, out_vld, i >= 3); end
`ifdef VAR_DELAY_FLUSH_EN
            if (m_busy()) begin
                checks++; if (d_out !== 8'd0) begin fails++; $display("FAIL midrst_flush cycle %0d: got %h want 00", i, d_out); end
            end
`endif
            s = m_ok() ? m_sample() : 9'd0;
            if (m_ok()) begin
                checks++; if (d_out !== s[7:0]) begin fails++; $display("FAIL midrst_out cycle %0d: got %h want %h", i, d_out, s[7:0]); end
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] s;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                 $urandom_range(0, 19) == 0, 9'($urandom_range(0, 24)), 0);
            s = m_ok() ? m_sample() : 9'd0;
            checks++; if (out_vld !== (m_ok() && s[8])) begin fails++; $display("FAIL rnd_vld cycle %0d: got %b want %b", i, out_vld, m_ok() && s[8]); end
            checks++; if (busy !== m_busy()) begin fails++; $display("FAIL rnd_busy cycle %0d: got %b want %b", i, busy, m_busy()); end
            checks++; if (cfg_ack !== m_ack) begin fails++; $display("FAIL rnd_ack cycle %0d: got %b want %b", i, cfg_ack, m_ack); end
            checks++; if (cfg_err !== m_err) begin fails++; $display("FAIL rnd_err cycle %0d: got %b want %b", i, cfg_err, m_err); end
            if (m_ok()) begin
                checks++; if (d_out !== s[7:0]) begin fails++; $display("FAIL rnd_out cycle %0d: got %h want %h", i, d_out, s[7:0]); end
            end
`ifdef VAR_DELAY_FLUSH_EN
            if (m_busy()) begin
                checks++; if (d_out !== 8'd0) begin fails++; $display("FAIL rnd_flush cycle %0d: got %h want 00", i, d_out); end
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; d_in = '0; in_vld = 1'b0; cfg_req = 1'b0; cfg_dly = '0;
        m_d = 3; m_cnt = 0; m_err = 0; m_ack = 0;
        test_reset();
        test_latency();
        test_reconfig();
        test_clamp();
        test_en_toggle();
        test_fill_restart();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
